// File: rtl/cpu_step_5_writeback.sv
// Writeback stage of the 5-stage CPU: retires step-4 instructions into the register file,
// waiting on memory for loads. Optional same-cycle bypass to step 2 under CPU_STEP_5_FORWARD_EN.
module cpu_step_5_writeback #(
    parameter int WIDTH       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_step_4,
    input  logic             reg_write_step_4,
    input  logic             is_load_step_4,
    input  logic [4:0]       dest_step_4,
    input  logic [WIDTH-1:0] alu_result_step_4,
    input  logic [1:0]       load_size_step_4,
    input  logic             load_signed_step_4,
    input  logic [1:0]       addr_low_step_4,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
`ifdef CPU_STEP_5_FORWARD_EN
    input  logic [4:0]       rs_step_2,
    input  logic [4:0]       rt_step_2,
    output logic             fwd_rs_hit,
    output logic             fwd_rt_hit,
    output logic [WIDTH-1:0] fwd_data,
`endif
    output logic [4:0]       wnum_step_5,
    output logic [WIDTH-1:0] wdata_step_5,
    output logic             is_write_reg_step_5,
    output logic             stall_step_5,
    output logic             mem_timeout_err
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q;
    logic [4:0]       dest_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic [1:0]       addr_q;
    logic [7:0]       cnt_q;
    logic [4:0]       wnum_q;
    logic [WIDTH-1:0] wdata_q;
    logic             wr_q;
    logic             err_q;
    logic [WIDTH-1:0] load_data_d;

    // Select the addressed little-endian lane and widen it to the datapath.
    function automatic logic [WIDTH-1:0] extract_load(
        input logic [WIDTH-1:0] rdata,
        input logic [1:0]       size,
        input logic             sgn,
        input logic [1:0]       addr
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (addr)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   extract_load = {{(WIDTH-8){sgn & b[7]}}, b};
            2'b01:   extract_load = {{(WIDTH-16){sgn & h[15]}}, h};
            default: extract_load = rdata;
        endcase
    endfunction

    assign load_data_d = extract_load(mem_rdata, size_q, signed_q, addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            wnum_q   <= 5'd0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            dest_q   <= 5'd0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= 2'd0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_step_4 && reg_write_step_4) begin
                        if (is_load_step_4) begin
                            dest_q   <= dest_step_4;
                            size_q   <= load_size_step_4;
                            signed_q <= load_signed_step_4;
                            addr_q   <= addr_low_step_4;
                            cnt_q    <= 8'd0;
                            state_q  <= WAIT_MEM;
                        end else if (dest_step_4 != 5'd0) begin
                            wr_q    <= 1'b1;
                            wnum_q  <= dest_step_4;
                            wdata_q <= alu_result_step_4;
                        end
                    end
                end
                WAIT_MEM: begin
                    // A response on the final timeout cycle still completes the load.
                    if (mem_rvalid) begin
                        if (dest_q != 5'd0) begin
                            wr_q    <= 1'b1;
                            wnum_q  <= dest_q;
                            wdata_q <= load_data_d;
                        end
                        state_q <= IDLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign wnum_step_5         = wnum_q;
    assign wdata_step_5        = wdata_q;
    assign is_write_reg_step_5 = wr_q;
    assign stall_step_5        = (state_q == WAIT_MEM);
    assign mem_timeout_err     = err_q;

`ifdef CPU_STEP_5_FORWARD_EN
    assign fwd_rs_hit = wr_q && (wnum_q == rs_step_2) && (wnum_q != 5'd0);
    assign fwd_rt_hit = wr_q && (wnum_q == rt_step_2) && (wnum_q != 5'd0);
    assign fwd_data   = wdata_q;
`endif

endmodule

// File: tb/tb_cpu_step_5_writeback.sv
// Directed self-checking bench for cpu_step_5_writeback (MEM_TIMEOUT=4).
module tb_cpu_step_5_writeback;

    logic        clk;
    logic        rst;
    logic        valid_step_4;
    logic        reg_write_step_4;
    logic        is_load_step_4;
    logic [4:0]  dest_step_4;
    logic [31:0] alu_result_step_4;
    logic [1:0]  load_size_step_4;
    logic        load_signed_step_4;
    logic [1:0]  addr_low_step_4;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  wnum_step_5;
    logic [31:0] wdata_step_5;
    logic        is_write_reg_step_5;
    logic        stall_step_5;
    logic        mem_timeout_err;
`ifdef CPU_STEP_5_FORWARD_EN
    logic [4:0]  rs_step_2;
    logic [4:0]  rt_step_2;
    logic        fwd_rs_hit;
    logic        fwd_rt_hit;
    logic [31:0] fwd_data;
`endif

    int errors = 0;
    int checks = 0;

    cpu_step_5_writeback #(.WIDTH(32), .MEM_TIMEOUT(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .valid_step_4        (valid_step_4),
        .reg_write_step_4    (reg_write_step_4),
        .is_load_step_4      (is_load_step_4),
        .dest_step_4         (dest_step_4),
        .alu_result_step_4   (alu_result_step_4),
        .load_size_step_4    (load_size_step_4),
        .load_signed_step_4  (load_signed_step_4),
        .addr_low_step_4     (addr_low_step_4),
        .mem_rvalid          (mem_rvalid),
        .mem_rdata           (mem_rdata),
`ifdef CPU_STEP_5_FORWARD_EN
        .rs_step_2           (rs_step_2),
        .rt_step_2           (rt_step_2),
        .fwd_rs_hit          (fwd_rs_hit),
        .fwd_rt_hit          (fwd_rt_hit),
        .fwd_data            (fwd_data),
`endif
        .wnum_step_5         (wnum_step_5),
        .wdata_step_5        (wdata_step_5),
        .is_write_reg_step_5 (is_write_reg_step_5),
        .stall_step_5        (stall_step_5),
        .mem_timeout_err     (mem_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_step_4       = 1'b0;
        reg_write_step_4   = 1'b0;
        is_load_step_4     = 1'b0;
        dest_step_4        = 5'd0;
        alu_result_step_4  = 32'd0;
        load_size_step_4   = 2'b10;
        load_signed_step_4 = 1'b0;
        addr_low_step_4    = 2'd0;
        mem_rvalid         = 1'b0;
        mem_rdata          = 32'd0;
    endtask

    task automatic alu_write(input logic [4:0] dest, input logic [31:0] val);
        valid_step_4      = 1'b1;
        reg_write_step_4  = 1'b1;
        is_load_step_4    = 1'b0;
        dest_step_4       = dest;
        alu_result_step_4 = val;
        tick();
        valid_step_4      = 1'b0;
    endtask

    task automatic start_load(input logic [4:0] dest, input logic [1:0] size,
                              input logic sgn, input logic [1:0] addr);
        valid_step_4       = 1'b1;
        reg_write_step_4   = 1'b1;
        is_load_step_4     = 1'b1;
        dest_step_4        = dest;
        load_size_step_4   = size;
        load_signed_step_4 = sgn;
        addr_low_step_4    = addr;
        tick();
        valid_step_4       = 1'b0;
        is_load_step_4     = 1'b0;
    endtask

    task automatic mem_return(input logic [31:0] data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        checks++; if (is_write_reg_step_5 !== 1'b0) begin errors++; $display("FAIL reset_wr: got %0b want 0", is_write_reg_step_5); end
        checks++; if (wnum_step_5 !== 5'd0) begin errors++; $display("FAIL reset_wnum: got %0d want 0", wnum_step_5); end
        checks++; if (wdata_step_5 !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata_step_5); end
        checks++; if (stall_step_5 !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall_step_5); end
        checks++; if (mem_timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", mem_timeout_err); end
    endtask

    task automatic test_alu_write();
        valid_step_4      = 1'b1;
        reg_write_step_4  = 1'b1;
        dest_step_4       = 5'd5;
        alu_result_step_4 = 32'h1234_5678;
        #1;
        checks++; if (stall_step_5 !== 1'b0) begin errors++; $display("FAIL alu_stall_pre: got %0b want 0", stall_step_5); end
        tick();
        valid_step_4 = 1'b0;
        checks++; if (is_write_reg_step_5 !== 1'b1) begin errors++; $display("FAIL alu_wr: got %0b want 1", is_write_reg_step_5); end
        checks++; if (wnum_step_5 !== 5'd5) begin errors++; $display("FAIL alu_wnum: got %0d want 5", wnum_step_5); end
        checks++; if (wdata_step_5 !== 32'h1234_5678) begin errors++; $display("FAIL alu_wdata: got %h want 12345678", wdata_step_5); end
        checks++; if (stall_step_5 !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0b want 0", stall_step_5); end
        tick();
        checks++; if (is_write_reg_step_5 !== 1'b0) begin errors++; $display("FAIL alu_pulse_end: got %0b want 0", is_write_reg_step_5); end
        checks++; if (wdata_step_5 !== 32'h1234_5678) begin errors++; $display("FAIL alu_hold: got %h want 12345678", wdata_step_5); end
        // reg_write=0 retires without a write
        valid_step_4      = 1'b1;
        reg_write_step_4  = 1'b0;
        dest_step_4       = 5'd6;
        alu_result_step_4 = 32'h0BAD_0BAD;
        tick();
        idle_inputs();
        checks++; if (is_write_reg_step_5 !== 1'b0) begin errors++; $display("FAIL nowrite_wr: got %0b want 0", is_write_reg_step_5); end
        checks++; if (wnum_step_5 !== 5'd5) begin errors++; $display("FAIL nowrite_wnum: got %0d want 5", wnum_step_5); end
    endtask

    task automatic test_load_byte_signed();
        start_load(5'd3, 2'b00, 1'b1, 2'd3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall_step_5 !== 1'b1) begin errors++; $display("FAIL lb_stall_%0d: got %0b want 1", i, stall_step_5); end
            checks++; if (is_write_reg_step_5 !== 1'b0) begin errors++; $display("FAIL lb_early_wr_%0d: got %0b want 0", i, is_write_reg_step_5); end
            if (i < 2) tick();
        end
        mem_return(32'h80FF_0011);
        checks++; if (is_write_reg_step_5 !== 1'b1) begin errors++; $display("FAIL lb_wr: got %0b want 1", is_write_reg_step_5); end
        checks++; if (wnum_step_5 !== 5'd3) begin errors++; $display("FAIL lb_wnum: got %0d want 3", wnum_step_5); end
        checks++; if (wdata_step_5 !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wdata: got %h want ffffff80", wdata_step_5); end
        checks++; if (stall_step_5 !== 1'b0) begin errors++; $display("FAIL lb_stall_drop: got %0b want 0", stall_step_5); end
    endtask

    task automatic test_load_lanes();
        start_load(5'd9, 2'b01, 1'b0, 2'd2);
        mem_return(32'hBEEF_1234);
        checks++; if (wdata_step_5 !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_wdata: got %h want 0000beef", wdata_step_5); end
        checks++; if (wnum_step_5 !== 5'd9) begin errors++; $display("FAIL lhu_wnum: got %0d want 9", wnum_step_5); end
        start_load(5'd10, 2'b10, 1'b1, 2'd1);
        mem_return(32'hCAFE_F00D);
        checks++; if (wdata_step_5 !== 32'hCAFE_F00D) begin errors++; $display("FAIL lw_wdata: got %h want cafef00d", wdata_step_5); end
        start_load(5'd11, 2'b01, 1'b1, 2'd1);
        mem_return(32'h0001_8001);
        checks++; if (wdata_step_5 !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_wdata: got %h want ffff8001", wdata_step_5); end
        start_load(5'd12, 2'b00, 1'b0, 2'd1);
        mem_return(32'h0000_A500);
        checks++; if (wdata_step_5 !== 32'h0000_00A5) begin errors++; $display("FAIL lbu_wdata: got %h want 000000a5", wdata_step_5); end
        start_load(5'd13, 2'b00, 1'b1, 2'd0);
        mem_return(32'hFFFF_FF7F);
        checks++; if (wdata_step_5 !== 32'h0000_007F) begin errors++; $display("FAIL lb_pos_wdata: got %h want 0000007f", wdata_step_5); end
    endtask

    task automatic test_dest_zero();
        alu_write(5'd4, 32'h0000_0011);
        alu_write(5'd0, 32'h0000_DEAD);
        checks++; if (is_write_reg_step_5 !== 1'b0) begin errors++; $display("FAIL d0_alu_wr: got %0b want 0", is_write_reg_step_5); end
        checks++; if (wnum_step_5 !== 5'd4) begin errors++; $display("FAIL d0_alu_wnum: got %0d want 4", wnum_step_5); end
        checks++; if (wdata_step_5 !== 32'h0000_0011) begin errors++; $display("FAIL d0_alu_wdata: got %h want 00000011", wdata_step_5); end
        start_load(5'd0, 2'b10, 1'b0, 2'd0);
        checks++; if (stall_step_5 !== 1'b1) begin errors++; $display("FAIL d0_ld_stall: got %0b want 1", stall_step_5); end
        mem_return(32'hFFFF_FFFF);
        checks++; if (is_write_reg_step_5 !== 1'b0) begin errors++; $display("FAIL d0_ld_wr: got %0b want 0", is_write_reg_step_5); end
        checks++; if (stall_step_5 !== 1'b0) begin errors++; $display("FAIL d0_ld_stall_drop: got %0b want 0", stall_step_5); end
        checks++; if (wdata_step_5 !== 32'h0000_0011) begin errors++; $display("FAIL d0_ld_wdata: got %h want 00000011", wdata_step_5); end
    endtask

    task automatic test_timeout();
        start_load(5'd6, 2'b10, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (stall_step_5 !== 1'b1) begin errors++; $display("FAIL to_stall_%0d: got %0b want 1", i, stall_step_5); end
            checks++; if (mem_timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_early_%0d: got %0b want 0", i, mem_timeout_err); end
            tick();
        end
        checks++; if (mem_timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %0b want 1", mem_timeout_err); end
        checks++; if (stall_step_5 !== 1'b0) begin errors++; $display("FAIL to_stall_drop: got %0b want 0", stall_step_5); end
        checks++; if (is_write_reg_step_5 !== 1'b0) begin errors++; $display("FAIL to_wr: got %0b want 0", is_write_reg_step_5); end
        mem_return(32'h1111_1111);
        checks++; if (is_write_reg_step_5 !== 1'b0) begin errors++; $display("FAIL to_late_rvalid_wr: got %0b want 0", is_write_reg_step_5); end
        alu_write(5'd2, 32'h2);
        checks++; if (mem_timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %0b want 1", mem_timeout_err); end
        do_reset();
        checks++; if (mem_timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %0b want 0", mem_timeout_err); end
    endtask

    task automatic test_timeout_rvalid_wins();
        start_load(5'd8, 2'b10, 1'b0, 2'd0);
        tick();
        tick();
        tick();
        checks++; if (stall_step_5 !== 1'b1) begin errors++; $display("FAIL tw_stall: got %0b want 1", stall_step_5); end
        mem_return(32'h5A5A_5A5A);
        checks++; if (is_write_reg_step_5 !== 1'b1) begin errors++; $display("FAIL tw_wr: got %0b want 1", is_write_reg_step_5); end
        checks++; if (wdata_step_5 !== 32'h5A5A_5A5A) begin errors++; $display("FAIL tw_wdata: got %h want 5a5a5a5a", wdata_step_5); end
        checks++; if (mem_timeout_err !== 1'b0) begin errors++; $display("FAIL tw_err: got %0b want 0", mem_timeout_err); end
        checks++; if (stall_step_5 !== 1'b0) begin errors++; $display("FAIL tw_stall_drop: got %0b want 0", stall_step_5); end
    endtask

    task automatic test_reset_in_wait();
        start_load(5'd12, 2'b10, 1'b0, 2'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_return(32'h0000_0077);
        checks++; if (is_write_reg_step_5 !== 1'b0) begin errors++; $display("FAIL rw_wr: got %0b want 0", is_write_reg_step_5); end
        checks++; if (stall_step_5 !== 1'b0) begin errors++; $display("FAIL rw_stall: got %0b want 0", stall_step_5); end
        checks++; if (wnum_step_5 !== 5'd0) begin errors++; $display("FAIL rw_wnum: got %0d want 0", wnum_step_5); end
        alu_write(5'd14, 32'h0000_0E0E);
        checks++; if (wdata_step_5 !== 32'h0000_0E0E) begin errors++; $display("FAIL rw_idle_alu: got %h want 00000e0e", wdata_step_5); end
    endtask

    task automatic test_back_to_back();
        valid_step_4     = 1'b1;
        reg_write_step_4 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            dest_step_4       = 5'(i + 16);
            alu_result_step_4 = 32'hA000_0000 + 32'(i);
            tick();
            checks++; if (is_write_reg_step_5 !== 1'b1 || wnum_step_5 !== 5'(i + 16) || wdata_step_5 !== 32'hA000_0000 + 32'(i))
                begin errors++; $display("FAIL b2b_%0d: got wr=%0b wnum=%0d wdata=%h want wr=1 wnum=%0d wdata=%h", i, is_write_reg_step_5, wnum_step_5, wdata_step_5, i + 16, 32'hA000_0000 + 32'(i)); end
        end
        idle_inputs();
        tick();
    endtask

`ifdef CPU_STEP_5_FORWARD_EN
    task automatic test_forward();
        rs_step_2 = 5'd7;
        rt_step_2 = 5'd8;
        alu_write(5'd7, 32'h0000_ABCD);
        checks++; if (fwd_rs_hit !== 1'b1) begin errors++; $display("FAIL fwd_rs_hit: got %0b want 1", fwd_rs_hit); end
        checks++; if (fwd_rt_hit !== 1'b0) begin errors++; $display("FAIL fwd_rt_hit: got %0b want 0", fwd_rt_hit); end
        checks++; if (fwd_data !== 32'h0000_ABCD) begin errors++; $display("FAIL fwd_data: got %h want 0000abcd", fwd_data); end
        tick();
        checks++; if (fwd_rs_hit !== 1'b0) begin errors++; $display("FAIL fwd_rs_idle: got %0b want 0", fwd_rs_hit); end
    endtask
`endif

    initial begin
        rst = 1'b0;
`ifdef CPU_STEP_5_FORWARD_EN
        rs_step_2 = 5'd0;
        rt_step_2 = 5'd0;
`endif
        idle_inputs();
        test_reset();
        test_alu_write();
        test_load_byte_signed();
        test_load_lanes();
        test_dest_zero();
        test_timeout();
        test_timeout_rvalid_wins();
        test_reset_in_wait();
        test_back_to_back();
`ifdef CPU_STEP_5_FORWARD_EN
        test_forward();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_step_5_writeback.md
Name: cpu_step_5_writeback

Overview:
- Writeback stage (step 5) of the 5-stage CPU. It is the writer side of the register-file port that step 2 reads.
- Accepts retiring instructions from step 4 and waits on the data-memory read response for loads.
- Performs load lane extraction and sign/zero extension.
- Drives wnum_step_5 / wdata_step_5 / is_write_reg_step_5 into the register file, and stalls upstream while a load is outstanding.

Parameters:
WIDTH, 32, datapath width; only 32 is supported.
MEM_TIMEOUT, 15, WAIT_MEM cycles without mem_rvalid before the load is abandoned; legal range 1..255.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
valid_step_4  input  1  step 4 presents an instruction.
reg_write_step_4  input  1  instruction writes a register.
is_load_step_4  input  1  instruction is a load; result comes from memory.
dest_step_4  input  5  destination register number.
alu_result_step_4  input  WIDTH  ALU result for non-load writes.
load_size_step_4  input  2  00 byte, 01 half, 10/11 word.
load_signed_step_4  input  1  1 = sign-extend, 0 = zero-extend.
addr_low_step_4  input  2  byte address bits [1:0] of the load.
mem_rvalid  input  1  memory read data valid.
mem_rdata  input  WIDTH  memory read data, little-endian lanes.
wnum_step_5  output  5  register-file write number.
wdata_step_5  output  WIDTH  register-file write data.
is_write_reg_step_5  output  1  register-file write enable, one-cycle pulse.
stall_step_5  output  1  upstream must hold step 4.
mem_timeout_err  output  1  sticky load-timeout flag.

Behaviour:
- Reset: state IDLE; wnum_step_5=0, wdata_step_5=0, is_write_reg_step_5=0, mem_timeout_err=0; timeout counter 0.
  - Reset during WAIT_MEM discards the load.
  - An mem_rvalid arriving after reset is ignored.
- States: IDLE, WAIT_MEM.
- stall_step_5 = (state==WAIT_MEM), decoded combinationally from the state register.
- IDLE acceptance: an instruction is accepted on a cycle where valid_step_4=1.
  - Not accepted if reg_write_step_4=0; it retires with no write.
  - Non-load with reg_write: next cycle is_write_reg_step_5=1, wnum=dest, wdata=alu_result. Latency 1; state stays IDLE, so back-to-back acceptance is allowed every cycle.
  - Load with reg_write: capture dest, size, signed, addr_low. Go to WAIT_MEM and clear the counter.
- mem_rvalid in IDLE: ignored.
- WAIT_MEM:
  - mem_rvalid=1: extract and extend the data. Next cycle is_write_reg_step_5=1 with the loaded value, state returns to IDLE, and stall drops in that same cycle.
  - No mem_rvalid: the counter increments.
  - Counter reaches MEM_TIMEOUT-1 with no rvalid: set mem_timeout_err, do not write, return to IDLE.
  - mem_rvalid on the timeout cycle wins: normal write, no error.
- Extraction:
  - Byte: lane = mem_rdata[8*addr_low +: 8].
  - Half: lane = mem_rdata[16*addr_low[1] +: 16]; addr_low[0] is ignored.
  - Word: addr_low is ignored.
  - Extension to WIDTH uses the lane MSB when load_signed=1, zeros otherwise.
- dest=0: is_write_reg_step_5 stays 0, but the instruction still retires, including load wait and timeout.
- When no write occurs, is_write_reg_step_5=0 and wnum/wdata hold their last values.
- mem_timeout_err is cleared only by rst.

Optional Feature:
- Macro: CPU_STEP_5_FORWARD_EN.
- Defined: adds inputs rs_step_2[4:0] and rt_step_2[4:0], and outputs fwd_rs_hit, fwd_rt_hit (1 bit each) and fwd_data (WIDTH).
  - fwd_x_hit = is_write_reg_step_5 && (wnum_step_5==x_step_2) && (wnum_step_5!=0). This is combinational.
  - fwd_data = wdata_step_5.
  - Lets step 2 bypass a same-cycle register-file write.
- Undefined: these ports do not exist; there is no added logic.

Test Plan:
- Reset then non-load: valid, reg_write, dest=5, alu=0x12345678 -> next cycle write pulse wnum=5, wdata=0x12345678, stall=0 throughout.
- Signed byte load: addr_low=3, size=00, signed=1, rvalid 2 cycles after entering WAIT_MEM with rdata=0x80FF0011 -> stall high 3 cycles, then write data=0xFFFFFF80.
- Unsigned half load: addr_low=2, rdata=0xBEEF1234 -> write 0x0000BEEF; a word load with addr_low=1 -> the full rdata is written.
- dest=0 non-load and dest=0 load -> no write pulse in either case; stall behaviour for the load is unchanged.
- Timeout with MEM_TIMEOUT=4, no rvalid -> mem_timeout_err rises after 4 WAIT_MEM cycles with no write. A second run with rvalid on exactly the 4th cycle -> normal write, err stays 0.
- Reset asserted in WAIT_MEM, rvalid on the next cycle -> no write, state IDLE, stall=0. With CPU_STEP_5_FORWARD_EN: a write to 7 with rs_step_2=7 -> fwd_rs_hit=1 and fwd_data equals wdata.
